// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, ALU opcodes and opcode class decode
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_DEST_W = 3;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_NOT     = 4'b0101;
  localparam logic [3:0] OP_SHL     = 4'b0110;
  localparam logic [3:0] OP_SAR     = 4'b0111;
  localparam logic [3:0] OP_SHR     = 4'b1000;
  localparam logic [3:0] OP_MOV     = 4'b1001;
  localparam logic [3:0] OP_MOVH    = 4'b1010;
  localparam logic [3:0] OP_MOVL    = 4'b1011;
  localparam logic [3:0] OP_CMP     = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL = 4'b1101;
  localparam logic [3:0] OP_CMPU    = 4'b1110;
  localparam logic [3:0] OP_TST     = 4'b1111;

  typedef struct packed {
    logic push;
    logic upd_flags;
    logic illegal;
  } op_class_t;

  function automatic op_class_t decode_op(input logic [3:0] sel);
    op_class_t c;
    c = '0;
    if (sel <= OP_SHR) begin
      c.push      = 1'b1;
      c.upd_flags = 1'b1;
    end else if (sel <= OP_MOVL) begin
      c.push = 1'b1;
    end else if (sel == OP_ILLEGAL) begin
      c.illegal = 1'b1;
    end else begin
      c.upd_flags = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with count/full/empty
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // When empty, present the most recently popped entry rather than stale storage.
  assign o_rd_data = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU writeback stage: result FIFO, Z/N flags, sticky illegal-op error
module alu_result_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEST_W = CPU_DEST_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_select,
  input  logic [DEST_W-1:0] in_dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              flag_z,
  output logic              flag_n,
  output logic              err_illegal,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  op_class_t                w_class;
  logic                     w_accept;
  logic [CNT_W-1:0]         w_count;
  logic                     w_full;
  logic                     w_empty;
  logic [DEST_W+DATA_W-1:0] w_head;
  logic                     r_flag_z;
  logic                     r_flag_n;
  logic                     r_err;

  assign w_class  = decode_op(in_select);
  // Ready depends only on the registered count, so a same-cycle pop never admits a push.
  assign in_ready = (w_count < CNT_W'(DEPTH));
  assign w_accept = in_valid && in_ready;

  sync_fifo #(
    .WIDTH(DEST_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_accept && w_class.push),
    .i_wr_data({in_dest, in_result}),
    .i_pop    (wb_ready),
    .o_rd_data(w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign wb_valid = !w_empty;
  assign wb_data  = w_head[DATA_W-1:0];
  assign wb_dest  = w_head[DEST_W+DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept && w_class.upd_flags) begin
        r_flag_z <= (in_result == '0);
        r_flag_n <= in_result[DATA_W-1];
      end
      if (w_accept && w_class.illegal) r_err <= 1'b1;
      else if (err_clr)                r_err <= 1'b0;
    end
  end

  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;
  assign err_illegal = r_err;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_select;
  logic [2:0]  in_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        flag_z;
  logic        flag_n;
  logic        err_illegal;
  logic        err_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(16), .DEST_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_select(in_select), .in_dest(in_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .flag_z(flag_z), .flag_n(flag_n), .err_illegal(err_illegal), .err_clr(err_clr)
  );

  task automatic drive(input logic v, input logic [3:0] sel, input logic [15:0] res, input logic [2:0] d);
    in_valid  = v;
    in_select = sel;
    in_result = res;
    in_dest   = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wb_ready = 1'b0; err_clr = 1'b0;
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    repeat (2) @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    tests++; if (wb_data !== 16'h0) begin fails++; $display("FAIL reset_wb_data got %h want 0000", wb_data); end
    tests++; if (wb_dest !== 3'd0) begin fails++; $display("FAIL reset_wb_dest got %0d want 0", wb_dest); end
    tests++; if ({flag_z, flag_n, err_illegal} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {flag_z, flag_n, err_illegal}); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_zero;
    wb_ready = 1'b1;
    drive(1'b1, 4'b0000, 16'h0000, 3'd3);
    @(negedge clk);
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL add_wb_valid got %b want 1", wb_valid); end
    tests++; if (wb_data !== 16'h0000) begin fails++; $display("FAIL add_wb_data got %h want 0000", wb_data); end
    tests++; if (wb_dest !== 3'd3) begin fails++; $display("FAIL add_wb_dest got %0d want 3", wb_dest); end
    tests++; if ({flag_z, flag_n} !== 2'b10) begin fails++; $display("FAIL add_flags got %b want 10", {flag_z, flag_n}); end
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL add_popped got %b want 0", wb_valid); end
  endtask

  task automatic test_full_backpressure;
    wb_ready = 1'b0;
    drive(1'b1, 4'b0001, 16'h8001, 3'd1);
    @(negedge clk);
    drive(1'b1, 4'b1001, 16'h0005, 3'd5);
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    tests++; if ({flag_z, flag_n} !== 2'b01) begin fails++; $display("FAIL full_flags_after_mov got %b want 01", {flag_z, flag_n}); end
    drive(1'b1, 4'b0000, 16'h1234, 3'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (in_ready !== 1'b0 || wb_data !== 16'h8001) begin
        fails++; $display("FAIL full_hold cycle %0d got ready=%b data=%h want ready=0 data=8001", i, in_ready, wb_data);
      end
    end
    tests++; if ({flag_z, flag_n} !== 2'b01) begin fails++; $display("FAIL full_flags_held got %b want 01", {flag_z, flag_n}); end
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    wb_ready = 1'b1;
    tests++; if (wb_valid !== 1'b1 || wb_data !== 16'h8001 || wb_dest !== 3'd1) begin
      fails++; $display("FAIL drain_first got v=%b %h/%0d want 1 8001/1", wb_valid, wb_data, wb_dest);
    end
    @(negedge clk);
    tests++; if (wb_valid !== 1'b1 || wb_data !== 16'h0005 || wb_dest !== 3'd5) begin
      fails++; $display("FAIL drain_second got v=%b %h/%0d want 1 0005/5", wb_valid, wb_data, wb_dest);
    end
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", wb_valid); end
  endtask

  task automatic test_compare;
    wb_ready = 1'b0;
    drive(1'b1, 4'b0000, 16'h0007, 3'd2);
    @(negedge clk);
    drive(1'b1, 4'b1100, 16'h0000, 3'd6);
    @(negedge clk);
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    tests++; if (flag_z !== 1'b1) begin fails++; $display("FAIL cmp_flag_z got %b want 1", flag_z); end
    tests++; if (in_ready !== 1'b1 || wb_data !== 16'h0007) begin
      fails++; $display("FAIL cmp_no_push got ready=%b data=%h want 1 0007", in_ready, wb_data);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL cmp_count_one got wb_valid=%b want 0", wb_valid); end
  endtask

  task automatic test_illegal;
    drive(1'b1, 4'b1101, 16'h8000, 3'd4);
    @(negedge clk);
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_set got %b want 1", err_illegal); end
    tests++; if (wb_valid !== 1'b0 || {flag_z, flag_n} !== 2'b10) begin
      fails++; $display("FAIL ill_side got v=%b zn=%b want 0 10", wb_valid, {flag_z, flag_n});
    end
    err_clr = 1'b1;
    @(negedge clk);
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_set_priority got %b want 1", err_illegal); end
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    @(negedge clk);
    err_clr = 1'b0;
    tests++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL ill_clr got %b want 0", err_illegal); end
  endtask

  task automatic test_back_to_back;
    wb_ready = 1'b0;
    drive(1'b1, 4'b0000, 16'd1, 3'd1);
    @(negedge clk);
    wb_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tests++; if (wb_valid !== 1'b1 || in_ready !== 1'b1 || wb_data !== 16'(i) || wb_dest !== 3'(i)) begin
        fails++; $display("FAIL b2b step %0d got v=%b r=%b %h/%0d want 1 1 %h/%0d", i, wb_valid, in_ready, wb_data, wb_dest, 16'(i), 3'(i));
      end
      if (i < 10) drive(1'b1, 4'b0010, 16'(i + 1), 3'(i + 1));
      else        drive(1'b0, 4'b0000, 16'h0000, 3'd0);
      @(negedge clk);
    end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", wb_valid); end
  endtask

  task automatic test_async_reset;
    wb_ready = 1'b0;
    drive(1'b1, 4'b1101, 16'h0000, 3'd0);
    @(negedge clk);
    drive(1'b1, 4'b0001, 16'h8001, 3'd1);
    @(negedge clk);
    drive(1'b1, 4'b0000, 16'h9000, 3'd2);
    @(negedge clk);
    drive(1'b0, 4'b0000, 16'h0000, 3'd0);
    tests++; if (in_ready !== 1'b0 || err_illegal !== 1'b1 || flag_n !== 1'b1) begin
      fails++; $display("FAIL arst_pre got r=%b err=%b n=%b want 0 1 1", in_ready, err_illegal, flag_n);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (wb_valid !== 1'b0 || {flag_z, flag_n, err_illegal} !== 3'b000 || in_ready !== 1'b1) begin
      fails++; $display("FAIL arst_async got v=%b zne=%b r=%b want 0 000 1", wb_valid, {flag_z, flag_n, err_illegal}, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== 16'h0) begin
      fails++; $display("FAIL arst_after got v=%b r=%b d=%h want 0 1 0000", wb_valid, in_ready, wb_data);
    end
  endtask

  initial begin
    test_reset;
    test_add_zero;
    test_full_backpressure;
    test_compare;
    test_illegal;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
